// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, error codes and FSM states for the load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RMW_READ, S_STORE, S_RESP
  } state_t;
endpackage

// File: rtl/lsu_align_32.sv
// lsu_align_32: combinational lane extraction/extension for loads and lane merge for sub-word stores.
//   i_addr[1:0] byte offset, i_size access size, i_unsigned zero-extend loads,
//   i_old word read from memory, i_wdata right-aligned store data,
//   o_load extended load data, o_merged old word with the target lane replaced.
module lsu_align_32
  import lsu_pkg::*;
(
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);
  logic [4:0]  w_sh;
  logic [31:0] w_lane_mask;
  logic [31:0] w_shifted;
  // Half accesses only use addr[1]; aligned words always shift by zero.
  assign w_sh        = i_size == SZ_HALF ? {i_addr[1], 4'b0000} : {i_addr, 3'b000};
  assign w_lane_mask = i_size == SZ_BYTE ? 32'h0000_00FF : i_size == SZ_HALF ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign w_shifted   = i_old >> w_sh;
  assign o_load      = i_size == SZ_BYTE ? {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]} :
                       i_size == SZ_HALF ? {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]} :
                       w_shifted;
  assign o_merged    = (i_old & ~(w_lane_mask << w_sh)) | ((i_wdata & w_lane_mask) << w_sh);
endmodule

// File: rtl/lsu_32.sv
// lsu_32: load/store unit converting byte-addressed requests into word accesses on a 32-bit data memory.
//   req_*  request channel from MEM stage (req_ready high only in IDLE),
//   resp_* one-cycle completion pulse with extended load data and error code,
//   mem_*  word-indexed memory port (combinational read, synchronous write).
module lsu_32
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);
  state_t      r_state;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wbuf;
  logic [31:0] r_rdata;
  logic [1:0]  r_error;
  logic [1:0]  w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  // Misalignment (including the reserved size) outranks out-of-range.
  assign w_err = (req_size == 2'b11 || (req_size == SZ_HALF && req_addr[0]) ||
                  (req_size == SZ_WORD && req_addr[1:0] != 2'b00)) ? ERR_ALIGN :
                 req_addr >= LIMIT ? ERR_RANGE : ERR_NONE;
  lsu_align_32 u_align (
    .i_addr     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_old      (mem_read_data),
    .i_wdata    (r_wbuf),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wbuf     <= '0;
      r_rdata    <= '0;
      r_error    <= ERR_NONE;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_size     <= req_size;
          r_unsigned <= req_unsigned;
          r_addr     <= req_addr;
          r_wbuf     <= req_wdata;
          r_rdata    <= '0;
          r_error    <= w_err;
          r_state    <= w_err != ERR_NONE ? S_RESP : !req_write ? S_LOAD :
                        req_size == SZ_WORD ? S_STORE : S_RMW_READ;
        end
        S_LOAD: begin
          r_rdata <= w_load;
          r_state <= S_RESP;
        end
        S_RMW_READ: begin
          r_wbuf  <= w_merged;
          r_state <= S_STORE;
        end
        S_STORE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign req_ready      = r_state == S_IDLE;
  assign resp_valid     = r_state == S_RESP;
  assign resp_rdata     = resp_valid ? r_rdata : '0;
  assign resp_error     = resp_valid ? r_error : ERR_NONE;
  assign mem_read       = r_state == S_LOAD || r_state == S_RMW_READ;
  assign mem_write      = r_state == S_STORE;
  assign mem_address    = (mem_read || mem_write) ? {2'b00, r_addr[31:2]} : '0;
  assign mem_write_data = mem_write ? r_wbuf : '0;
endmodule

// File: tb/tb_lsu_32.sv
// tb_lsu_32: self-checking bench for lsu_32 against a byte-array reference model.
module tb_lsu_32;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic [31:0] mem [0:31];
  logic [7:0]  rb [0:127];
  int total = 0;
  int passes = 0;

  lsu_32 #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = mem[mem_address[4:0]];
  always @(posedge clk) if (mem_write) mem[mem_address[4:0]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_error"}, 32'(resp_error), 32'd0);
    check({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'd0);
    check({tag, "_addr"}, mem_address, 32'd0);
    check({tag, "_wdata"}, mem_write_data, 32'd0);
  endtask

  // One request through the DUT; expectations come from the byte-level model.
  task automatic run(input logic wr, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd);
    int n;
    int e;
    int lat_exp;
    int lat;
    longint v;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    n = 1 << sz;
    v = 0;
    exp_rd = '0;
    exp_word = '0;
    lat = 0;
    e = (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)) ? 1 :
        (a >= 32'd128) ? 2 : 0;
    if (e == 0 && !wr) begin
      for (int i = 0; i < n; i++) v = v | (longint'(rb[int'(a) + i]) << (8 * i));
      if (!u && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      exp_rd = v[31:0];
    end
    if (e == 0 && wr) begin
      for (int i = 0; i < n; i++) rb[int'(a) + i] = wd[8*i +: 8];
      exp_word = ref_word(int'(a >> 2));
    end
    lat_exp = e != 0 ? 1 : (!wr || sz == 2'd2) ? 2 : 3;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check("ready_busy", 32'(req_ready), 32'd0);
      check("rw_excl", 32'(mem_read & mem_write), 32'd0);
      if (e != 0) check("err_nostrobe", 32'({mem_read, mem_write}), 32'd0);
      if (!mem_read && !mem_write) begin
        check("addr_quiet", mem_address, 32'd0);
        check("wdata_quiet", mem_write_data, 32'd0);
      end else begin
        check("mem_addr", mem_address, a >> 2);
      end
      if (mem_write) check("mem_wdata", mem_write_data, exp_word);
      if (resp_valid) begin
        lat = c;
        break;
      end
      check("rdata_hold0", resp_rdata, 32'd0);
      check("error_hold0", 32'(resp_error), 32'd0);
    end
    check("latency", 32'(lat), 32'(lat_exp));
    check("resp_rdata", resp_rdata, exp_rd);
    check("resp_error", 32'(resp_error), 32'(e));
  endtask

  initial begin
    logic [31:0] w;
    logic [1:0] sz;
    logic [31:0] a;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_unsigned = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      w = (i == 1) ? 32'h8899AABB : $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) rb[4*i+b] = w[8*b +: 8];
    end
    rst = 1'b1;
    #1 check_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 2'd0, 1'b0, 32'h7, 32'h0);
    run(1'b0, 2'd0, 1'b1, 32'h7, 32'h0);
    run(1'b1, 2'd1, 1'b0, 32'h6, 32'hDEAD1234);
    check("sh_word1", mem[1], 32'h1234AABB);
    run(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    run(1'b1, 2'd2, 1'b0, 32'h5, 32'h0BADF00D);
    check("misaligned_sw_word1", mem[1], 32'h1234AABB);
    run(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
    run(1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
    run(1'b0, 2'd1, 1'b0, 32'h81, 32'h0);
    mem[1] = 32'h8899AABB;
    for (int b = 0; b < 4; b++) rb[4+b] = mem[1][8*b +: 8];
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'd0;
    req_addr = 32'h4;
    req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 check("rmw_reached", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_no_write", mem[1], 32'h8899AABB);
    run(1'b1, 2'd2, 1'b0, 32'h8, 32'hCAFEF00D);
    run(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    check("b2b_word2", mem[2], 32'hCAFEF00D);
    for (int k = 0; k < 80; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(128, 300)) : 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~(32'(1 << sz) - 32'd1);
      run(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) check("final_mem", mem[i], ref_word(i));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
